// File: rtl/generic_uncount_1.sv
// Count-to-thermometer expander with a 2-entry skid buffer on valid/ready handshakes.
// Optional per-word clamp flag output `sat` is enabled by defining GENERIC_UNCOUNT_SAT_EN.
module generic_uncount_1 #(
   parameter int WIDTH = 32,
   parameter int DEPTH = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DEPTH-1:0] count_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d_out
`ifdef GENERIC_UNCOUNT_SAT_EN
   ,
   output logic             sat
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

   buf_state_t       state;
   logic [WIDTH-1:0] main_p0;
   logic [WIDTH-1:0] skid_p0;
   logic             acc;
   logic             drn;

   // Counts at or beyond WIDTH fill every bit, so non-power-of-2 widths clamp naturally.
   function automatic logic [WIDTH-1:0] expand(input logic [DEPTH-1:0] cnt);
      logic [WIDTH-1:0] res;
      res = '0;
      for (int i = 0; i < WIDTH; i++) begin
         res[i] = (i < int'(cnt));
      end
      return res;
   endfunction

`ifdef GENERIC_UNCOUNT_SAT_EN
   logic sat_main_p0;
   logic sat_skid_p0;

   function automatic logic is_sat(input logic [DEPTH-1:0] cnt);
      return int'(cnt) > WIDTH;
   endfunction

   assign sat = sat_main_p0;
`endif

   assign acc   = in_valid & in_ready;
   assign drn   = out_valid & out_ready;
   assign d_out = main_p0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         main_p0   <= '0;
         skid_p0   <= '0;
`ifdef GENERIC_UNCOUNT_SAT_EN
         sat_main_p0 <= 1'b0;
         sat_skid_p0 <= 1'b0;
`endif
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  main_p0   <= expand(count_in);
`ifdef GENERIC_UNCOUNT_SAT_EN
                  sat_main_p0 <= is_sat(count_in);
`endif
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (acc && !drn) begin
                  skid_p0  <= expand(count_in);
`ifdef GENERIC_UNCOUNT_SAT_EN
                  sat_skid_p0 <= is_sat(count_in);
`endif
                  in_ready <= 1'b0;
                  state    <= TWO;
               end else if (!acc && drn) begin
                  // main keeps its last word so d_out holds while idle
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end else if (acc && drn) begin
                  main_p0 <= expand(count_in);
`ifdef GENERIC_UNCOUNT_SAT_EN
                  sat_main_p0 <= is_sat(count_in);
`endif
               end
            end
            TWO: begin
               if (drn) begin
                  main_p0  <= skid_p0;
`ifdef GENERIC_UNCOUNT_SAT_EN
                  sat_main_p0 <= sat_skid_p0;
`endif
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_generic_uncount_1.sv
// Bench for generic_uncount_1: a WIDTH=32 and a WIDTH=20 instance checked against a FIFO model.
module tb_generic_uncount_1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv   [2];
   logic        ordy [2];
   logic [4:0]  cnt  [2];
   logic        a_rdy, a_vld, b_rdy, b_vld;
   logic [31:0] a_dout;
   logic [19:0] b_dout;
   logic        a_sat_w, b_sat_w;
`ifdef GENERIC_UNCOUNT_SAT_EN
   logic        a_sat, b_sat;
   assign a_sat_w = a_sat;
   assign b_sat_w = b_sat;
`else
   assign a_sat_w = 1'b0;
   assign b_sat_w = 1'b0;
`endif

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   generic_uncount_1 #(.WIDTH(32)) u_a (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(a_rdy), .count_in(cnt[0]),
      .out_valid(a_vld), .out_ready(ordy[0]), .d_out(a_dout)
`ifdef GENERIC_UNCOUNT_SAT_EN
      , .sat(a_sat)
`endif
   );

   generic_uncount_1 #(.WIDTH(20)) u_b (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(b_rdy), .count_in(cnt[1]),
      .out_valid(b_vld), .out_ready(ordy[1]), .d_out(b_dout)
`ifdef GENERIC_UNCOUNT_SAT_EN
      , .sat(b_sat)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] therm(input int c, input int w);
      int n;
      n = (c < w) ? c : w;
      return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
   endfunction

   // Model: a 2-deep FIFO of counts; the head word is what d_out shows.
   int          mq     [2][$];
   bit          m_rdy  [2];
   bit          m_vld  [2];
   logic [31:0] m_last [2];
   bit          m_lsat [2];
   int          wdt    [2] = '{32, 20};

   always @(posedge clk) begin
      bit acc, drn;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            mq[k].delete();
            m_rdy[k]  = 1'b1;
            m_vld[k]  = 1'b0;
            m_last[k] = '0;
            m_lsat[k] = 1'b0;
         end else begin
            acc = iv[k] && m_rdy[k];
            drn = m_vld[k] && ordy[k];
            if (drn) void'(mq[k].pop_front());
            if (acc) mq[k].push_back(int'(cnt[k]));
            m_rdy[k] = (mq[k].size() < 2);
            m_vld[k] = (mq[k].size() > 0);
            if (mq[k].size() > 0) begin
               m_last[k] = therm(mq[k][0], wdt[k]);
               m_lsat[k] = (mq[k][0] > wdt[k]);
            end
         end
      end
   end

   task automatic cmp_inst(input int k, input logic rdy, input logic vld,
                           input logic [31:0] dout, input logic satv);
      int pc;
      check($sformatf("u%0d_in_ready", k), {31'b0, rdy}, {31'b0, m_rdy[k]});
      check($sformatf("u%0d_out_valid", k), {31'b0, vld}, {31'b0, m_vld[k]});
      check($sformatf("u%0d_d_out", k), dout, m_last[k]);
`ifdef GENERIC_UNCOUNT_SAT_EN
      check($sformatf("u%0d_sat", k), {31'b0, satv}, {31'b0, m_lsat[k]});
`else
      if (satv !== 1'b0) check($sformatf("u%0d_sat_tie", k), {31'b0, satv}, 32'h0);
`endif
      if (m_vld[k]) begin
         pc = (mq[k][0] < wdt[k]) ? mq[k][0] : wdt[k];
         check($sformatf("u%0d_popcount", k), 32'($countones(dout)), 32'(pc));
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_inst(0, a_rdy, a_vld, a_dout, a_sat_w);
         cmp_inst(1, b_rdy, b_vld, {12'b0, b_dout}, b_sat_w);
      end
   end

   initial begin
      bit hr [2];
      int nacc;
      int cyc;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1; cnt[k] = '0;
      end
      @(posedge clk);
      chk_en = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("rst_in_ready", {31'b0, a_rdy}, 32'h1);
      check("rst_out_valid", {31'b0, a_vld}, 32'h0);
      check("rst_d_out", a_dout, 32'h0);

      // Back-to-back counts with free drain.
      iv[0] = 1'b1; cnt[0] = 5'd0;
      @(negedge clk); check("b2b_c0", a_dout, 32'h0); check("b2b_v0", {31'b0, a_vld}, 32'h1);
      cnt[0] = 5'd1;
      @(negedge clk); check("b2b_c1", a_dout, 32'h1);
      cnt[0] = 5'd5;
      @(negedge clk); check("b2b_c5", a_dout, 32'h1F);
      cnt[0] = 5'd31;
      @(negedge clk); check("b2b_c31", a_dout, 32'h7FFF_FFFF);
      iv[0] = 1'b0;
      @(negedge clk); check("b2b_drained", {31'b0, a_vld}, 32'h0);
      check("b2b_hold", a_dout, 32'h7FFF_FFFF);

      // Clamp on the 20-bit instance.
      iv[1] = 1'b1; cnt[1] = 5'd20;
      @(negedge clk); check("w20_c20", {12'b0, b_dout}, 32'hF_FFFF);
`ifdef GENERIC_UNCOUNT_SAT_EN
      check("w20_c20_sat", {31'b0, b_sat}, 32'h0);
`endif
      cnt[1] = 5'd31;
      @(negedge clk); check("w20_c31", {12'b0, b_dout}, 32'hF_FFFF);
`ifdef GENERIC_UNCOUNT_SAT_EN
      check("w20_c31_sat", {31'b0, b_sat}, 32'h1);
`endif
      iv[1] = 1'b0;

      // Backpressure fills both entries; the third word waits upstream.
      ordy[0] = 1'b0; iv[0] = 1'b1; cnt[0] = 5'd3;
      @(negedge clk); check("bp_d3", a_dout, 32'h7); check("bp_rdy1", {31'b0, a_rdy}, 32'h1);
      cnt[0] = 5'd7;
      @(negedge clk); check("bp_rdy0", {31'b0, a_rdy}, 32'h0); check("bp_hold3", a_dout, 32'h7);
      cnt[0] = 5'd9;
      @(negedge clk); check("bp_still0", {31'b0, a_rdy}, 32'h0); check("bp_hold3b", a_dout, 32'h7);
      ordy[0] = 1'b1;
      @(negedge clk); check("bp_d7", a_dout, 32'h7F); check("bp_rdy_back", {31'b0, a_rdy}, 32'h1);
      @(negedge clk); check("bp_d9", a_dout, 32'h1FF);
      iv[0] = 1'b0;
      @(negedge clk); check("bp_empty", {31'b0, a_vld}, 32'h0);

      // Sustained accept and drain.
      for (int i = 0; i < 10; i++) begin
         check("ad_in_ready", {31'b0, a_rdy}, 32'h1);
         iv[0] = 1'b1; cnt[0] = 5'($urandom_range(0, 31));
         @(negedge clk);
      end
      iv[0] = 1'b0;
      @(negedge clk);

      // Reset while both entries are full.
      ordy[0] = 1'b0; iv[0] = 1'b1; cnt[0] = 5'd11;
      @(negedge clk); cnt[0] = 5'd12;
      @(negedge clk); iv[0] = 1'b0;
      check("rt_two", {31'b0, a_rdy}, 32'h0);
      rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      check("rt_vld", {31'b0, a_vld}, 32'h0);
      check("rt_rdy", {31'b0, a_rdy}, 32'h1);
      check("rt_dout", a_dout, 32'h0);
      ordy[0] = 1'b1; iv[0] = 1'b1; cnt[0] = 5'd13;
      @(negedge clk); check("rt_first", a_dout, 32'h1FFF); check("rt_first_v", {31'b0, a_vld}, 32'h1);
      iv[0] = 1'b0;
      @(negedge clk); check("rt_no_replay", {31'b0, a_vld}, 32'h0);

      // Random handshakes on both instances; a pending offer is held until taken.
      nacc = 0; cyc = 0;
      hr[0] = a_rdy; hr[1] = b_rdy;
      while (nacc < 10000 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) begin
            if (iv[k] && hr[k] && k == 0) nacc++;
            if (!(iv[k] && !hr[k])) begin
               iv[k]  = 1'($urandom_range(0, 1));
               cnt[k] = 5'($urandom_range(0, 31));
            end
            ordy[k] = 1'($urandom_range(0, 1));
         end
         hr[0] = a_rdy; hr[1] = b_rdy;
      end
      if (cyc >= 60000) check("random_timeout", 32'(nacc), 32'd10000);
      iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b1; ordy[1] = 1'b1;
      repeat (4) @(negedge clk);
      check("final_empty_a", {31'b0, a_vld}, 32'h0);
      check("final_empty_b", {31'b0, b_vld}, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
